// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, the $zero index and the
// writeback-stage state type.
package mips_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        COMMIT
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake plus the register-file write port and forwarding taps.
// master = MEM stage / register file side, slave = writeback stage.
interface writeback_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
);
    logic                      inValid;
    logic                      inReady;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [REG_ADDR_WIDTH-1:0] writeRegisterIn;
    logic                      RegisterWriteIn;
    logic                      MemoryToRegisterIn;
    logic                      memDataValid;
    logic [DATA_WIDTH-1:0]     memData;
    logic                      flush;
    logic                      stall;
    logic [DATA_WIDTH-1:0]     writeBack;
    logic [REG_ADDR_WIDTH-1:0] writeRegister;
    logic                      RegisterWrite;
    logic                      fwdValid;
    logic [REG_ADDR_WIDTH-1:0] fwdRegister;
    logic [DATA_WIDTH-1:0]     fwdData;
    logic                      memTimeout;
    logic [CNT_WIDTH-1:0]      retiredCount;

    modport master (
        output inValid, aluResult, writeRegisterIn, RegisterWriteIn,
               MemoryToRegisterIn, memDataValid, memData, flush,
        input  inReady, stall, writeBack, writeRegister, RegisterWrite,
               fwdValid, fwdRegister, fwdData, memTimeout, retiredCount
    );

    modport slave (
        input  inValid, aluResult, writeRegisterIn, RegisterWriteIn,
               MemoryToRegisterIn, memDataValid, memData, flush,
        output inReady, stall, writeBack, writeRegister, RegisterWrite,
               fwdValid, fwdRegister, fwdData, memTimeout, retiredCount
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Counts cycles spent waiting for load data; expire_o flags the last
// permitted waiting cycle.
module wb_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// MIPS MEM/WB stage: retires instructions into the register file, waits for
// late load data with a timeout, and exposes the committing write for forwarding.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);
    wb_state_t                 state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] pend_reg_q, pend_reg_d;
    logic                      pend_we_q, pend_we_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [CNT_WIDTH-1:0]      retired_q, retired_d;
    logic                      timeout_q, timeout_d;

    logic                      accept;
    logic                      cnt_clear;
    logic                      cnt_expire;
    logic                      commit;
    logic [REG_ADDR_WIDTH-1:0] commit_reg;
    logic                      commit_we;
    logic [DATA_WIDTH-1:0]     commit_data;

    assign bus.inReady = !bus.flush && (state_q != WAIT_MEM);
    assign bus.stall   = (state_q == WAIT_MEM);
    assign accept      = bus.inValid && bus.inReady;

    wb_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cnt_clear),
        .enable_i (state_q == WAIT_MEM),
        .expire_o (cnt_expire)
    );

    always_comb begin
        state_d     = state_q;
        pend_reg_d  = pend_reg_q;
        pend_we_d   = pend_we_q;
        wr_en_d     = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        retired_d   = retired_q;
        timeout_d   = timeout_q;
        cnt_clear   = 1'b0;
        commit      = 1'b0;
        commit_reg  = bus.writeRegisterIn;
        commit_we   = bus.RegisterWriteIn;
        commit_data = bus.aluResult;

        unique case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (accept) begin
                    if (!bus.MemoryToRegisterIn) begin
                        commit = 1'b1;
                    end else if (bus.memDataValid) begin
                        commit      = 1'b1;
                        commit_data = bus.memData;
                    end else begin
                        state_d    = WAIT_MEM;
                        cnt_clear  = 1'b1;
                        pend_reg_d = bus.writeRegisterIn;
                        pend_we_d  = bus.RegisterWriteIn;
                    end
                end
            end
            WAIT_MEM: begin
                commit_reg  = pend_reg_q;
                commit_we   = pend_we_q;
                commit_data = bus.memData;
                // Priority: flush, then arriving data, then expiry.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.memDataValid) begin
                    commit = 1'b1;
                end else if (cnt_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes to $zero retire without touching the write port.
        if (commit) begin
            state_d   = COMMIT;
            retired_d = retired_q + 1'b1;
            if (commit_we && (commit_reg != REG_ADDR_WIDTH'(REG_ZERO))) begin
                wr_en_d   = 1'b1;
                wb_reg_d  = commit_reg;
                wb_data_d = commit_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_reg_q <= '0;
            pend_we_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_reg_q <= pend_reg_d;
            pend_we_q  <= pend_we_d;
            wr_en_q    <= wr_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.RegisterWrite = wr_en_q;
    assign bus.writeRegister = wb_reg_q;
    assign bus.writeBack     = wb_data_q;
    assign bus.fwdValid      = wr_en_q;
    assign bus.fwdRegister   = wb_reg_q;
    assign bus.fwdData       = wb_data_q;
    assign bus.memTimeout    = timeout_q;
    assign bus.retiredCount  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal
// expectations, then randomized traffic against an instruction-level model.
module tb_writeback_stage;
    import mips_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int TMO = 16;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    writeback_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .MEM_TIMEOUT    (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Instruction-level reference: one possibly-outstanding load, the last
    // register-file write, and running totals.
    bit            m_waiting   = 1'b0;
    int            m_waited    = 0;
    logic [AW-1:0] m_reg       = '0;
    bit            m_we        = 1'b0;
    bit            exp_wr      = 1'b0;
    logic [AW-1:0] exp_reg     = '0;
    logic [DW-1:0] exp_data    = '0;
    logic [CW-1:0] exp_retired = '0;
    bit            exp_timeout = 1'b0;

    task automatic model_commit(input logic [AW-1:0] rd, input bit we, input logic [DW-1:0] data);
        exp_retired = exp_retired + 1;
        if (we && rd != 0) begin
            exp_wr   = 1'b1;
            exp_reg  = rd;
            exp_data = data;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_waiting   = 1'b0;
            m_waited    = 0;
            exp_wr      = 1'b0;
            exp_reg     = '0;
            exp_data    = '0;
            exp_retired = '0;
            exp_timeout = 1'b0;
        end else begin
            exp_wr = 1'b0;
            if (m_waiting) begin
                m_waited++;
                if (bus.flush) begin
                    m_waiting = 1'b0;
                end else if (bus.memDataValid) begin
                    m_waiting = 1'b0;
                    model_commit(m_reg, m_we, bus.memData);
                end else if (m_waited == TMO) begin
                    m_waiting   = 1'b0;
                    exp_timeout = 1'b1;
                end
            end else if (bus.inValid && !bus.flush) begin
                if (!bus.MemoryToRegisterIn) begin
                    model_commit(bus.writeRegisterIn, bus.RegisterWriteIn, bus.aluResult);
                end else if (bus.memDataValid) begin
                    model_commit(bus.writeRegisterIn, bus.RegisterWriteIn, bus.memData);
                end else begin
                    m_waiting = 1'b1;
                    m_waited  = 0;
                    m_reg     = bus.writeRegisterIn;
                    m_we      = bus.RegisterWriteIn;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("RegisterWrite", bus.RegisterWrite, exp_wr);
            check("writeRegister", bus.writeRegister, exp_reg);
            check("writeBack",     bus.writeBack,     exp_data);
            check("fwdValid",      bus.fwdValid,      exp_wr);
            check("fwdRegister",   bus.fwdRegister,   exp_reg);
            check("fwdData",       bus.fwdData,       exp_data);
            check("memTimeout",    bus.memTimeout,    exp_timeout);
            check("retiredCount",  bus.retiredCount,  exp_retired);
            check("stall",         bus.stall,         m_waiting);
            check("inReady",       bus.inReady,       !bus.flush && !m_waiting);
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] alu, input logic [AW-1:0] rd,
                         input bit we, input bit m2r, input bit mdv,
                         input logic [DW-1:0] md, input bit fl);
        bus.inValid            = v;
        bus.aluResult          = alu;
        bus.writeRegisterIn    = rd;
        bus.RegisterWriteIn    = we;
        bus.MemoryToRegisterIn = m2r;
        bus.memDataValid       = mdv;
        bus.memData            = md;
        bus.flush              = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, ".RegisterWrite"}, bus.RegisterWrite, 0);
        check({tag, ".writeBack"},     bus.writeBack,     0);
        check({tag, ".writeRegister"}, bus.writeRegister, 0);
        check({tag, ".fwdValid"},      bus.fwdValid,      0);
        check({tag, ".memTimeout"},    bus.memTimeout,    0);
        check({tag, ".retiredCount"},  bus.retiredCount,  0);
        check({tag, ".inReady"},       bus.inReady,       1);
        check({tag, ".stall"},         bus.stall,         0);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_on = 1'b1;
        check_zero_state("reset");

        // ALU write to r1.
        drive(1'b1, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("alu.RegisterWrite", bus.RegisterWrite, 1);
        check("alu.writeRegister", bus.writeRegister, 1);
        check("alu.writeBack",     bus.writeBack,     32'hFFFFFFFF);
        check("alu.fwdValid",      bus.fwdValid,      1);
        check("alu.retiredCount",  bus.retiredCount,  1);
        tick();
        check("idle.RegisterWrite", bus.RegisterWrite, 0);
        check("idle.writeBack",     bus.writeBack,     32'hFFFFFFFF);

        // Write to $zero: retired but not written.
        drive(1'b1, 32'h0FFFFFFF, 5'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("zero.RegisterWrite", bus.RegisterWrite, 0);
        check("zero.retiredCount",  bus.retiredCount,  2);
        check("zero.writeBack",     bus.writeBack,     32'hFFFFFFFF);

        // Late load to r5.
        drive(1'b1, '0, 5'd5, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("load.stall",   bus.stall,   1);
        check("load.inReady", bus.inReady, 0);
        tick();
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        tick();
        check("load.RegisterWrite", bus.RegisterWrite, 1);
        check("load.writeRegister", bus.writeRegister, 5);
        check("load.writeBack",     bus.writeBack,     32'h12345678);
        check("load.retiredCount",  bus.retiredCount,  3);

        // Timeout after TMO waiting cycles.
        drive(1'b1, '0, 5'd7, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        repeat (TMO - 1) tick();
        check("tmo.pre_stall",   bus.stall,      1);
        check("tmo.pre_timeout", bus.memTimeout, 0);
        tick();
        check("tmo.memTimeout",    bus.memTimeout,    1);
        check("tmo.stall",         bus.stall,         0);
        check("tmo.RegisterWrite", bus.RegisterWrite, 0);
        check("tmo.retiredCount",  bus.retiredCount,  3);

        // Flush beats a simultaneous accept.
        drive(1'b1, 32'hDEADBEEF, 5'd9, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        #1 check("flush.inReady", bus.inReady, 0);
        tick();
        check("flush.RegisterWrite", bus.RegisterWrite, 0);
        check("flush.retiredCount",  bus.retiredCount,  3);

        // Flush beats memDataValid while waiting.
        drive(1'b1, '0, 5'd10, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555, 1'b1);
        tick();
        check("flushmem.RegisterWrite", bus.RegisterWrite, 0);
        check("flushmem.stall",         bus.stall,         0);
        check("flushmem.retiredCount",  bus.retiredCount,  3);

        // Data arriving on the last waiting cycle still commits.
        drive(1'b1, '0, 5'd11, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        repeat (TMO - 1) tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        tick();
        check("edge.RegisterWrite", bus.RegisterWrite, 1);
        check("edge.writeRegister", bus.writeRegister, 11);
        check("edge.writeBack",     bus.writeBack,     32'h0BADF00D);
        check("edge.retiredCount",  bus.retiredCount,  4);

        // Reset in the middle of a wait.
        drive(1'b1, '0, 5'd6, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();
        #1 rst = 1'b1;
        #1 check_zero_state("midrst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back ALU instructions to r1..r4.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(32'h100 * i), AW'(i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
            tick();
            check("b2b.RegisterWrite", bus.RegisterWrite, 1);
            check("b2b.writeRegister", bus.writeRegister, i);
            check("b2b.writeBack",     bus.writeBack,     32'h100 * i);
            check("b2b.stall",         bus.stall,         0);
        end
        check("b2b.retiredCount", bus.retiredCount, 4);
        tick();
        check("b2b.after_write", bus.RegisterWrite, 0);

        // Randomized traffic; the second half starves load data to provoke timeouts.
        for (int i = 0; i < 3000; i++) begin
            int mdv_pct;
            mdv_pct = (i < 1500) ? 30 : 3;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            drive($urandom_range(0, 9) < 6, $urandom, AW'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 99) < mdv_pct, $urandom,
                  $urandom_range(0, 99) < 6);
            @(posedge clk);
            #1;
        end

        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
